// File: rtl/branch_target_predictor.sv
// Direct-mapped BTB with per-entry saturating direction counters for the fetch stage.
// Latency: lookup is combinational (zero cycles); an update is visible from the next cycle.
// Backpressure: none; one update accepted every cycle, no ready signal.
//
// Ports:
//   clk, reset                 clock; synchronous active-high reset
//   lkp_pc -> lkp_hit, lkp_taken, lkp_next_pc
//                              fetch-side prediction (taken ? target : pc+4)
//   upd_valid, upd_pc, upd_taken, upd_uncond, upd_target, upd_pred_taken
//                              resolved branch/jump from EX
//   stat_lookups, stat_hits, stat_mispredicts
//                              statistics counters, present only when BTB_STATS_EN is defined
module branch_target_predictor #(
  parameter int XLEN     = 32,
  parameter int ENTRIES  = 16,
  parameter int CTR_BITS = 2,
  parameter int STAT_W   = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [XLEN-1:0] lkp_pc,
  output logic            lkp_hit,
  output logic            lkp_taken,
  output logic [XLEN-1:0] lkp_next_pc,
  input  logic            upd_valid,
  input  logic [XLEN-1:0] upd_pc,
  input  logic            upd_taken,
  input  logic            upd_uncond,
  input  logic [XLEN-1:0] upd_target,
  input  logic            upd_pred_taken
`ifdef BTB_STATS_EN
  ,
  output logic [STAT_W-1:0] stat_lookups,
  output logic [STAT_W-1:0] stat_hits,
  output logic [STAT_W-1:0] stat_mispredicts
`endif
);

  localparam int IDX_W = $clog2(ENTRIES);
  localparam int TAG_W = XLEN - IDX_W - 2;

  // Counter encodings: all-ones = strongly taken, MSB set = taken.
  // Allocation lands on weakly taken, reset on weakly not taken.
  localparam logic [CTR_BITS-1:0] CTR_MAX   = '1;
  localparam logic [CTR_BITS-1:0] CTR_ALLOC = CTR_BITS'(1 << (CTR_BITS - 1));
  localparam logic [CTR_BITS-1:0] CTR_RST   = CTR_BITS'((1 << (CTR_BITS - 1)) - 1);

  logic                valid_q  [ENTRIES];
  logic [CTR_BITS-1:0] ctr_q    [ENTRIES];
  logic [TAG_W-1:0]    tag_q    [ENTRIES];
  logic [XLEN-1:0]     target_q [ENTRIES];

  // ---------------------------------------------------------------- lookup
  logic [IDX_W-1:0] lkp_idx;
  logic [TAG_W-1:0] lkp_tag;

  assign lkp_idx     = lkp_pc[IDX_W+1:2];
  assign lkp_tag     = lkp_pc[XLEN-1:IDX_W+2];
  assign lkp_hit     = valid_q[lkp_idx] && (tag_q[lkp_idx] == lkp_tag);
  assign lkp_taken   = lkp_hit && ctr_q[lkp_idx][CTR_BITS-1];
  assign lkp_next_pc = lkp_taken ? target_q[lkp_idx] : lkp_pc + XLEN'(4);

  // ---------------------------------------------------------------- update
  logic [IDX_W-1:0]    upd_idx;
  logic [TAG_W-1:0]    upd_tag;
  logic                upd_hit;
  logic                upd_alloc;
  logic                upd_wr_ctr;
  logic                upd_wr_tgt;
  logic [CTR_BITS-1:0] upd_ctr_cur;
  logic [CTR_BITS-1:0] upd_ctr_nxt;

  assign upd_idx     = upd_pc[IDX_W+1:2];
  assign upd_tag     = upd_pc[XLEN-1:IDX_W+2];
  assign upd_hit     = valid_q[upd_idx] && (tag_q[upd_idx] == upd_tag);
  assign upd_ctr_cur = ctr_q[upd_idx];

  always_comb begin
    upd_alloc   = 1'b0;
    upd_wr_ctr  = 1'b0;
    upd_wr_tgt  = 1'b0;
    upd_ctr_nxt = upd_ctr_cur;
    if (upd_valid) begin
      if (upd_hit) begin
        upd_wr_ctr = 1'b1;
        if (upd_uncond) begin
          upd_ctr_nxt = CTR_MAX;
          upd_wr_tgt  = 1'b1;
        end else if (upd_taken) begin
          if (upd_ctr_cur != CTR_MAX) upd_ctr_nxt = upd_ctr_cur + CTR_BITS'(1);
          upd_wr_tgt = 1'b1;
        end else begin
          if (upd_ctr_cur != '0) upd_ctr_nxt = upd_ctr_cur - CTR_BITS'(1);
        end
      end else if (upd_taken) begin
        // Not-taken misses never allocate, so only taken misses reach here.
        upd_alloc   = 1'b1;
        upd_wr_ctr  = 1'b1;
        upd_wr_tgt  = 1'b1;
        upd_ctr_nxt = upd_uncond ? CTR_MAX : CTR_ALLOC;
      end
    end
  end

  // Valid and counter state carry reset; reset overrides any in-flight update.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_q[i] <= 1'b0;
        ctr_q[i]   <= CTR_RST;
      end
    end else begin
      if (upd_alloc)  valid_q[upd_idx] <= 1'b1;
      if (upd_wr_ctr) ctr_q[upd_idx]   <= upd_ctr_nxt;
    end
  end

  // Tags and targets are meaningless while valid=0, so they need no reset.
  always_ff @(posedge clk) begin
    if (upd_alloc)  tag_q[upd_idx]    <= upd_tag;
    if (upd_wr_tgt) target_q[upd_idx] <= upd_target;
  end

  // ---------------------------------------------------------------- stats
  logic unused_bits;

`ifdef BTB_STATS_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      stat_lookups     <= '0;
      stat_hits        <= '0;
      stat_mispredicts <= '0;
    end else begin
      stat_lookups <= stat_lookups + STAT_W'(1);
      if (lkp_hit) stat_hits <= stat_hits + STAT_W'(1);
      if (upd_valid && (upd_pred_taken != upd_taken))
        stat_mispredicts <= stat_mispredicts + STAT_W'(1);
    end
  end

  assign unused_bits = ^{lkp_pc[1:0], upd_pc[1:0]};
`else
  assign unused_bits = ^{lkp_pc[1:0], upd_pc[1:0], upd_pred_taken, (STAT_W > 0)};
`endif

endmodule

// File: tb/tb_branch_target_predictor.sv
// Bench for branch_target_predictor: directed vector table, stats sequence
// (when BTB_STATS_EN is defined) and a random phase against a behavioural model.
module tb_branch_target_predictor;

  localparam int XLEN     = 32;
  localparam int ENTRIES  = 16;
  localparam int CTR_BITS = 2;
  localparam int STAT_W   = 32;
  localparam int IDX_W    = 4;
  localparam int CMAX     = (1 << CTR_BITS) - 1;
  localparam int CTHR     = 1 << (CTR_BITS - 1);

  logic            clk = 1'b0;
  logic            reset;
  logic [XLEN-1:0] lkp_pc;
  logic            lkp_hit;
  logic            lkp_taken;
  logic [XLEN-1:0] lkp_next_pc;
  logic            upd_valid;
  logic [XLEN-1:0] upd_pc;
  logic            upd_taken;
  logic            upd_uncond;
  logic [XLEN-1:0] upd_target;
  logic            upd_pred_taken;
`ifdef BTB_STATS_EN
  logic [STAT_W-1:0] stat_lookups;
  logic [STAT_W-1:0] stat_hits;
  logic [STAT_W-1:0] stat_mispredicts;
`endif

  int n_cmp  = 0;
  int n_fail = 0;

  branch_target_predictor #(
    .XLEN(XLEN), .ENTRIES(ENTRIES), .CTR_BITS(CTR_BITS), .STAT_W(STAT_W)
  ) dut (
    .clk(clk),
    .reset(reset),
    .lkp_pc(lkp_pc),
    .lkp_hit(lkp_hit),
    .lkp_taken(lkp_taken),
    .lkp_next_pc(lkp_next_pc),
    .upd_valid(upd_valid),
    .upd_pc(upd_pc),
    .upd_taken(upd_taken),
    .upd_uncond(upd_uncond),
    .upd_target(upd_target),
    .upd_pred_taken(upd_pred_taken)
`ifdef BTB_STATS_EN
    ,
    .stat_lookups(stat_lookups),
    .stat_hits(stat_hits),
    .stat_mispredicts(stat_mispredicts)
`endif
  );

  always #5 clk = ~clk;

  // Inputs change on the falling edge; outputs are sampled 1 time unit later,
  // so every check sees the state written by the previous rising edge.
  task automatic drive(input logic r, input logic [31:0] lpc, input logic uv,
                       input logic [31:0] upc, input logic ut, input logic uu,
                       input logic [31:0] tgt, input logic up);
    @(negedge clk);
    reset = r; lkp_pc = lpc; upd_valid = uv; upd_pc = upc;
    upd_taken = ut; upd_uncond = uu; upd_target = tgt; upd_pred_taken = up;
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // ---------------------------------------------------------------- model
  typedef struct {
    bit          valid;
    int unsigned tag;
    int          ctr;
    logic [31:0] target;
  } ent_t;

  ent_t        m [ENTRIES];
  int unsigned m_lookups, m_hits, m_mis;

  function automatic int m_idx(input logic [31:0] pc);
    return int'((pc >> 2) % ENTRIES);
  endfunction

  function automatic int unsigned m_tag(input logic [31:0] pc);
    return pc >> (2 + IDX_W);
  endfunction

  function automatic bit m_hit(input logic [31:0] pc);
    return m[m_idx(pc)].valid && (m[m_idx(pc)].tag == m_tag(pc));
  endfunction

  function automatic bit m_taken(input logic [31:0] pc);
    return m_hit(pc) && (m[m_idx(pc)].ctr >= CTHR);
  endfunction

  function automatic logic [31:0] m_next(input logic [31:0] pc);
    logic [31:0] seq;
    seq = pc + 32'd4;
    return m_taken(pc) ? m[m_idx(pc)].target : seq;
  endfunction

  task automatic m_step(input logic r, input logic [31:0] lpc, input logic uv,
                        input logic [31:0] upc, input logic ut, input logic uu,
                        input logic [31:0] tgt, input logic up);
    int i;
    if (r) begin
      for (int k = 0; k < ENTRIES; k++) begin
        m[k].valid = 1'b0;
        m[k].ctr   = CTHR - 1;
      end
      m_lookups = 0; m_hits = 0; m_mis = 0;
      return;
    end
    m_lookups++;
    if (m_hit(lpc)) m_hits++;
    if (uv && (up != ut)) m_mis++;
    if (!uv) return;
    i = m_idx(upc);
    if (m_hit(upc)) begin
      if (uu) begin
        m[i].ctr = CMAX; m[i].target = tgt;
      end else if (ut) begin
        m[i].ctr = (m[i].ctr + 1 > CMAX) ? CMAX : m[i].ctr + 1;
        m[i].target = tgt;
      end else begin
        m[i].ctr = (m[i].ctr - 1 < 0) ? 0 : m[i].ctr - 1;
      end
    end else if (ut) begin
      m[i].valid = 1'b1; m[i].tag = m_tag(upc); m[i].target = tgt;
      m[i].ctr = uu ? CMAX : CTHR;
    end
  endtask

  // ---------------------------------------------------------------- vectors
  typedef struct {
    logic        rst;
    logic [31:0] lpc;
    logic        uv;
    logic [31:0] upc;
    logic        ut;
    logic        uu;
    logic [31:0] tgt;
    logic        chk;
    logic        eh;
    logic        et;
    logic [31:0] en;
  } vec_t;

  vec_t vecs[$];

  initial begin
    logic [31:0] r_lpc, r_upc, r_tgt;
    logic        r_rst, r_uv, r_ut, r_uu, r_up;
    int          tag_sel;

    reset = 1'b1; lkp_pc = '0; upd_valid = 1'b0; upd_pc = '0;
    upd_taken = 1'b0; upd_uncond = 1'b0; upd_target = '0; upd_pred_taken = 1'b0;

    //               rst   lpc           uv    upc           ut    uu    tgt           chk   eh    et    en
    vecs.push_back('{1'b1, 32'h100,      1'b0, 32'h0,        1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 32'h0});
    vecs.push_back('{1'b0, 32'h100,      1'b0, 32'h0,        1'b0, 1'b0, 32'h0,        1'b1, 1'b0, 1'b0, 32'h104});
    vecs.push_back('{1'b0, 32'h100,      1'b1, 32'h100,      1'b1, 1'b0, 32'h080,      1'b1, 1'b0, 1'b0, 32'h104});
    vecs.push_back('{1'b0, 32'h100,      1'b1, 32'h100,      1'b0, 1'b0, 32'h0,        1'b1, 1'b1, 1'b1, 32'h080});
    vecs.push_back('{1'b0, 32'h100,      1'b1, 32'h100,      1'b0, 1'b0, 32'h0,        1'b1, 1'b1, 1'b0, 32'h104});
    vecs.push_back('{1'b0, 32'h100,      1'b1, 32'h100,      1'b0, 1'b0, 32'h0,        1'b1, 1'b1, 1'b0, 32'h104});
    vecs.push_back('{1'b0, 32'h100,      1'b1, 32'h100,      1'b0, 1'b0, 32'h0,        1'b1, 1'b1, 1'b0, 32'h104});
    // ctr saturated at 0: one taken update only reaches 1, still not taken
    vecs.push_back('{1'b0, 32'h100,      1'b1, 32'h100,      1'b1, 1'b0, 32'h088,      1'b1, 1'b1, 1'b0, 32'h104});
    vecs.push_back('{1'b0, 32'h100,      1'b0, 32'h0,        1'b0, 1'b0, 32'h0,        1'b1, 1'b1, 1'b0, 32'h104});
    // aliasing at index 0: 0x140 replaces 0x100
    vecs.push_back('{1'b0, 32'h140,      1'b1, 32'h100,      1'b1, 1'b0, 32'h200,      1'b1, 1'b0, 1'b0, 32'h144});
    vecs.push_back('{1'b0, 32'h100,      1'b1, 32'h140,      1'b1, 1'b0, 32'h300,      1'b1, 1'b1, 1'b1, 32'h200});
    vecs.push_back('{1'b0, 32'h100,      1'b0, 32'h0,        1'b0, 1'b0, 32'h0,        1'b1, 1'b0, 1'b0, 32'h104});
    vecs.push_back('{1'b0, 32'h140,      1'b0, 32'h0,        1'b0, 1'b0, 32'h0,        1'b1, 1'b1, 1'b1, 32'h300});
    // reset clears, then same-cycle JAL lookup/update with no bypass
    vecs.push_back('{1'b1, 32'h140,      1'b0, 32'h0,        1'b0, 1'b0, 32'h0,        1'b1, 1'b1, 1'b1, 32'h300});
    vecs.push_back('{1'b0, 32'h140,      1'b0, 32'h0,        1'b0, 1'b0, 32'h0,        1'b1, 1'b0, 1'b0, 32'h144});
    vecs.push_back('{1'b0, 32'h100,      1'b1, 32'h100,      1'b1, 1'b1, 32'h400,      1'b1, 1'b0, 1'b0, 32'h104});
    vecs.push_back('{1'b0, 32'h100,      1'b1, 32'h100,      1'b0, 1'b0, 32'h0,        1'b1, 1'b1, 1'b1, 32'h400});
    vecs.push_back('{1'b0, 32'h100,      1'b0, 32'h0,        1'b0, 1'b0, 32'h0,        1'b1, 1'b1, 1'b1, 32'h400});
    // reset concurrent with a taken update: nothing allocated, old entry gone
    vecs.push_back('{1'b1, 32'h104,      1'b1, 32'h104,      1'b1, 1'b0, 32'h500,      1'b1, 1'b0, 1'b0, 32'h108});
    vecs.push_back('{1'b0, 32'h104,      1'b0, 32'h0,        1'b0, 1'b0, 32'h0,        1'b1, 1'b0, 1'b0, 32'h108});
    vecs.push_back('{1'b0, 32'h100,      1'b0, 32'h0,        1'b0, 1'b0, 32'h0,        1'b1, 1'b0, 1'b0, 32'h104});
    // next_pc wraps; pc[1:0] ignored for index/tag
    vecs.push_back('{1'b0, 32'hFFFFFFFC, 1'b0, 32'h0,        1'b0, 1'b0, 32'h0,        1'b1, 1'b0, 1'b0, 32'h0});
    vecs.push_back('{1'b0, 32'h203,      1'b1, 32'h202,      1'b1, 1'b0, 32'h600,      1'b1, 1'b0, 1'b0, 32'h207});
    vecs.push_back('{1'b0, 32'h201,      1'b0, 32'h0,        1'b0, 1'b0, 32'h0,        1'b1, 1'b1, 1'b1, 32'h600});

    foreach (vecs[i]) begin
      drive(vecs[i].rst, vecs[i].lpc, vecs[i].uv, vecs[i].upc,
            vecs[i].ut, vecs[i].uu, vecs[i].tgt, 1'b0);
      if (vecs[i].chk) begin
        check($sformatf("vec%0d hit", i), 32'(lkp_hit), 32'(vecs[i].eh));
        check($sformatf("vec%0d taken", i), 32'(lkp_taken), 32'(vecs[i].et));
        check($sformatf("vec%0d next_pc", i), lkp_next_pc, vecs[i].en);
      end
    end

`ifdef BTB_STATS_EN
    // 10 counted cycles, 3 hits, 2 mispredicted updates
    drive(1'b1, 32'h0,   1'b0, 32'h0,   1'b0, 1'b0, 32'h0,  1'b0);
    drive(1'b0, 32'h0,   1'b1, 32'h100, 1'b1, 1'b0, 32'h80, 1'b0);
    drive(1'b0, 32'h100, 1'b0, 32'h0,   1'b0, 1'b0, 32'h0,  1'b0);
    drive(1'b0, 32'h100, 1'b1, 32'h100, 1'b1, 1'b0, 32'h80, 1'b1);
    drive(1'b0, 32'h100, 1'b0, 32'h0,   1'b0, 1'b0, 32'h0,  1'b0);
    drive(1'b0, 32'h0,   1'b1, 32'h500, 1'b0, 1'b0, 32'h0,  1'b1);
    for (int k = 0; k < 5; k++)
      drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
    @(negedge clk); #1;
    check("stats lookups", stat_lookups, 32'd10);
    check("stats hits", stat_hits, 32'd3);
    check("stats mispredicts", stat_mispredicts, 32'd2);
    drive(1'b1, 32'h700, 1'b1, 32'h700, 1'b1, 1'b0, 32'h900, 1'b0);
    drive(1'b0, 32'h700, 1'b0, 32'h0,   1'b0, 1'b0, 32'h0,   1'b0);
    check("stats lookups after reset", stat_lookups, 32'd0);
    check("stats hits after reset", stat_hits, 32'd0);
    check("stats mispredicts after reset", stat_mispredicts, 32'd0);
    check("no alloc during reset", 32'(lkp_hit), 32'd0);
    check("next_pc after reset", lkp_next_pc, 32'h704);
`endif

    // ---------------------------------------------------------------- random
    for (int c = 0; c < 3000; c++) begin
      r_rst = (c == 0) || ($urandom_range(0, 149) == 0);
      tag_sel = $urandom_range(0, 3);
      r_upc = ((tag_sel == 3) ? (32'hFFFFFFFF >> (2 + IDX_W)) : 32'(tag_sel)) << (2 + IDX_W);
      r_upc = r_upc | (32'($urandom_range(0, ENTRIES - 1)) << 2) | 32'($urandom_range(0, 3));
      if ($urandom_range(0, 2) == 0) begin
        r_lpc = r_upc;
      end else begin
        tag_sel = $urandom_range(0, 3);
        r_lpc = ((tag_sel == 3) ? (32'hFFFFFFFF >> (2 + IDX_W)) : 32'(tag_sel)) << (2 + IDX_W);
        r_lpc = r_lpc | (32'($urandom_range(0, ENTRIES - 1)) << 2) | 32'($urandom_range(0, 3));
      end
      r_uv  = 1'($urandom_range(0, 1));
      r_uu  = ($urandom_range(0, 4) == 0);
      r_ut  = r_uu | 1'($urandom_range(0, 1));
      r_tgt = $urandom & 32'hFFFFFFFC;
      r_up  = 1'($urandom_range(0, 1));

      drive(r_rst, r_lpc, r_uv, r_upc, r_ut, r_uu, r_tgt, r_up);
      if (c != 0) begin
        check("rand hit", 32'(lkp_hit), 32'(m_hit(r_lpc)));
        check("rand taken", 32'(lkp_taken), 32'(m_taken(r_lpc)));
        check("rand next_pc", lkp_next_pc, m_next(r_lpc));
`ifdef BTB_STATS_EN
        check("rand stat_lookups", stat_lookups, m_lookups);
        check("rand stat_hits", stat_hits, m_hits);
        check("rand stat_mispredicts", stat_mispredicts, m_mis);
`endif
      end
      m_step(r_rst, r_lpc, r_uv, r_upc, r_ut, r_uu, r_tgt, r_up);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
